rand_word_assembler: RTL and testbench
======================================

// Module: rand_word_assembler
// PURPOSE
//  Downstream consumer of the 4-bit LFSR serial random bit (its Q output).
//  - Collects WIDTH consecutive bits into a parallel random word on request.
//  - Presents the word through a valid/ready handshake to game logic.
//  - Optionally rejects out-of-range words so that results are uniform over 0..MAX_VAL.
// PARAMETERS
//  WIDTH    8    random word width in bits; legal range 2..16
//  MAX_VAL  199  largest accepted value (RAND_REJECT_EN only); must be < 2**WIDTH
//  GAP      2    idle cycles after each handshake, to decorrelate successive words; 0 allowed
// PORTS
//  clk         in   1      system clock, rising edge
//  reset       in   1      asynchronous, active-low reset
//  rnd_bit     in   1      serial random bit from the LFSR, sampled every clk
//  start       in   1      request one word; acted on only in IDLE
//  rnd_word    out  WIDTH  assembled word; stable while rnd_valid=1
//  rnd_valid   out  1      word available
//  rnd_ready   in   1      consumer accepts the word when rnd_valid & rnd_ready at an edge
//  busy        out  1      high in every state other than IDLE
//  reject_cnt  out  8      count of rejected words; saturates at 255
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, rnd_word=0, rnd_valid=0, busy=0, reject_cnt=0,
//   shift register=0, bit_cnt=0, gap_cnt=0. Any partial word is discarded.
//  FSM states: IDLE, COLLECT, HOLD, GAPW.
//  - IDLE: busy=0.
//    - start=1 at edge E0 -> COLLECT, bit_cnt=0.
//  - COLLECT: busy=1.
//    - Each edge: shreg <= {shreg[WIDTH-2:0], rnd_bit}, so the MSB is the first bit received.
//    - The bit sampled at edge Ek is bit k of the word, k=1..WIDTH.
//    - At edge EW, word = {shreg[WIDTH-2:0], rnd_bit}:
//      - accepted: rnd_word <= word, rnd_valid <= 1, -> HOLD.
//      - rejected: reject_cnt += 1 (saturating), bit_cnt <= 0, stay in COLLECT,
//        and collect a fresh WIDTH bits.
//    - Latency: rnd_valid goes high after edge EW, i.e. WIDTH edges after the start edge,
//      when no rejection occurs.
//  - HOLD: rnd_valid=1 and rnd_word held constant.
//    - At an edge with rnd_ready=1: rnd_valid <= 0, then GAP>0 -> GAPW, gap_cnt=0;
//      GAP==0 -> IDLE.
//    - rnd_word keeps its last value after the handshake; it does not clear.
//  - GAPW: busy=1; rnd_bit ignored; after GAP edges -> IDLE.
//  - start is ignored outside IDLE and is not queued.
//  - start held high continuously gives back-to-back words. The gap between a handshake
//    and the next start acceptance is GAP+1 edges, or 1 edge when GAP=0.
//  - rnd_ready outside HOLD is ignored.
//  - rnd_valid never drops without a handshake, except on reset.
//  - reject_cnt clears only on reset.
// CONFIGURATION
//  Macro RAND_REJECT_EN:
//  - Defined: a word is rejected when word > MAX_VAL, otherwise accepted.
//  - Not defined: every word is accepted, MAX_VAL is unused, and reject_cnt is tied to 0.
//  - The port list is identical in both builds.
// TESTING
//  1. reset=0 mid-run with rnd_ready=0 -> rnd_valid=0, rnd_word=0, busy=0, reject_cnt=0
//     immediately, without waiting for a clk edge.
//  2. WIDTH=8, GAP=2, start pulse, rnd_bit=1,0,1,1,0,0,1,0:
//     - rnd_word=8'hB2 and rnd_valid=1 after edge E8.
//     - Hold rnd_ready=0 for 20 cycles -> rnd_word unchanged.
//     - Pulse rnd_ready -> rnd_valid=0 at the next edge, busy stays 1 for 2 more edges,
//       then busy=0.
//  3. RAND_REJECT_EN, MAX_VAL=199, bits for 8'hF0 then 8'h64 -> reject_cnt=1,
//     rnd_word=8'h64, rnd_valid rises after E16.
//  4. RAND_REJECT_EN undefined, same stimulus as 3 -> rnd_word=8'hF0 after E8,
//     reject_cnt=0.
//  5. Reset pulse after 4 collected bits, then start with bits 8'h3C -> rnd_word=8'h3C.
//     No stale bits from before the reset appear in the word.
//  6. start held high, rnd_ready=1, GAP=2 -> rnd_valid pulses periodically.
//     start pulses during COLLECT or HOLD do not alter the word or the timing.
//     255+ rejections -> reject_cnt stays at 255.

Source files
------------

// File: rtl/rand_word_assembler_if.sv
// rand_word_assembler_if
//   Bundles the request, serial-bit, word handshake and status signals of
//   rand_word_assembler. Signal prefixes (i_/o_) are from the assembler's
//   point of view.
//   Modports:
//     slave  - the assembler. Inputs: i_start, i_rnd_bit, i_rnd_ready.
//              Outputs: o_rnd_word, o_rnd_valid, o_busy, o_reject_cnt.
//     master - the LFSR/game-logic side. Same signals, opposite directions.
//   Parameter:
//     WIDTH  - random word width. It must match the assembler's WIDTH.
interface rand_word_assembler_if #(
  parameter int WIDTH = 8
);
  logic             i_start;
  logic             i_rnd_bit;
  logic             i_rnd_ready;
  logic [WIDTH-1:0] o_rnd_word;
  logic             o_rnd_valid;
  logic             o_busy;
  logic [7:0]       o_reject_cnt;

  modport slave (
    input  i_start, i_rnd_bit, i_rnd_ready,
    output o_rnd_word, o_rnd_valid, o_busy, o_reject_cnt
  );

  modport master (
    output i_start, i_rnd_bit, i_rnd_ready,
    input  o_rnd_word, o_rnd_valid, o_busy, o_reject_cnt
  );
endinterface

// File: rtl/rand_word_assembler.sv
// rand_word_assembler
//   Collects WIDTH consecutive serial random bits from the LFSR into a word.
//   The first bit received becomes the MSB of the word. The word is then
//   offered to game logic through a valid/ready handshake. After each
//   handshake the block waits GAP idle cycles, so that consecutive words
//   do not share a run of LFSR bits.
//   Optional feature (macro RAND_REJECT_EN):
//     When RAND_REJECT_EN is defined, a completed word greater than MAX_VAL
//     is dropped and a fresh word is collected. o_reject_cnt counts these
//     rejections and saturates at 255.
//     When RAND_REJECT_EN is not defined, every word is accepted and
//     o_reject_cnt stays 0. The port list is the same in both builds.
//   Ports:
//     i_clk   - system clock, rising edge
//     i_rst_n - asynchronous reset, active low
//     bus     - rand_word_assembler_if.slave:
//               i_start      - request one word; only acted on in IDLE
//               i_rnd_bit    - serial random bit, sampled every clock
//               i_rnd_ready  - consumer accepts the word
//               o_rnd_word   - assembled word; held stable while valid
//               o_rnd_valid  - word available
//               o_busy       - high in every state except IDLE
//               o_reject_cnt - saturating count of rejected words
//   Parameters:
//     WIDTH   - word width, 2..16
//     MAX_VAL - largest accepted value (used with RAND_REJECT_EN only)
//     GAP     - idle cycles after each handshake; 0 is allowed
module rand_word_assembler #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 199,
  parameter int GAP     = 2
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  rand_word_assembler_if.slave  bus
);

`ifdef RAND_REJECT_EN
  localparam bit REJECT_EN = 1'b1;
`else
  localparam bit REJECT_EN = 1'b0;
`endif

  localparam int BCW = $clog2(WIDTH);
  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2,
    GAPW    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [WIDTH-2:0]   r_shiftReg;
  logic [BCW-1:0]     r_bitCnt;
  logic [GCW-1:0]     r_gapCnt;
  logic [WIDTH-1:0]   r_word;
  logic               r_valid;
  logic [7:0]         r_rejectCnt;
  logic [WIDTH-1:0]   w_word;
  logic               w_lastBit;
  logic               w_reject;
  logic               w_gapDone;

  // The shift register only needs WIDTH-1 bits. The word is completed by
  // appending the bit that arrives on the final collect edge.
  assign w_word    = {r_shiftReg, bus.i_rnd_bit};
  assign w_lastBit = (r_state == COLLECT) && (r_bitCnt == BCW'(WIDTH - 1));
  // REJECT_EN is a constant. In the default build it removes the comparison.
  assign w_reject  = REJECT_EN && (w_word > WIDTH'(MAX_VAL));
  assign w_gapDone = (r_gapCnt == GCW'(GAP - 1));

  assign bus.o_rnd_word   = r_word;
  assign bus.o_rnd_valid  = r_valid;
  assign bus.o_busy       = (r_state != IDLE);
  assign bus.o_reject_cnt = r_rejectCnt;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic.
  // A rejected word keeps the FSM in COLLECT so that a fresh word is built.
  // With GAP == 0 the handshake returns the FSM straight to IDLE.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (bus.i_start) w_stateNext = COLLECT;
      COLLECT: if (w_lastBit && !w_reject) w_stateNext = HOLD;
      HOLD:    if (bus.i_rnd_ready) w_stateNext = (GAP > 0) ? GAPW : IDLE;
      GAPW:    if (w_gapDone) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Datapath: bit collection, word capture, handshake flag, gap timer and
  // reject counter.
  // r_word is left unchanged after the handshake so that consumers may
  // still read it. Reset discards any partially collected word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shiftReg  <= '0;
      r_bitCnt    <= '0;
      r_gapCnt    <= '0;
      r_word      <= '0;
      r_valid     <= 1'b0;
      r_rejectCnt <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) r_bitCnt <= '0;
        end
        COLLECT: begin
          r_shiftReg <= w_word[WIDTH-2:0];
          if (w_lastBit) begin
            r_bitCnt <= '0;
            if (w_reject) begin
              if (r_rejectCnt != 8'hFF) r_rejectCnt <= r_rejectCnt + 8'd1;
            end else begin
              r_word  <= w_word;
              r_valid <= 1'b1;
            end
          end else begin
            r_bitCnt <= r_bitCnt + BCW'(1);
          end
        end
        HOLD: begin
          if (bus.i_rnd_ready) begin
            r_valid  <= 1'b0;
            r_gapCnt <= '0;
          end
        end
        GAPW: begin
          r_gapCnt <= r_gapCnt + GCW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_word_assembler.sv
// tb_rand_word_assembler
//   Directed, self-checking bench for rand_word_assembler with the default
//   parameters WIDTH=8, MAX_VAL=199 and GAP=2.
//   A table of words is applied one after another. Each entry holds the
//   hand-computed expected word for both builds, so the bench works with
//   RAND_REJECT_EN defined or not.
//   Hand-written sequences cover these cases: a long hold, asynchronous
//   reset, a partial word cut off by reset, back-to-back words with start
//   held high, and saturation of the reject counter.
module tb_rand_word_assembler;

`ifdef RAND_REJECT_EN
  localparam bit REJ_EN = 1'b1;
`else
  localparam bit REJ_EN = 1'b0;
`endif

  typedef struct {
    logic [7:0] first;
    logic [7:0] second;
    logic [7:0] expEn;
    logic [7:0] expDis;
    logic       rejEn;
  } vec_t;

  logic clk;
  logic rst_n;
  int   assertCount;
  int   failCount;
  int   expRej;
  vec_t vecs [6];

  rand_word_assembler_if #(.WIDTH(8)) bus ();

  rand_word_assembler #(
    .WIDTH  (8),
    .MAX_VAL(199),
    .GAP    (2)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startPulse();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  // Shifts in eight bits, MSB first, one per edge.
  task automatic applyStimulus(input logic [7:0] bits);
    for (int i = 7; i >= 0; i--) begin
      bus.i_rnd_bit = bits[i];
      tick();
    end
  endtask

  // Handshake, then the two-edge gap, then back to IDLE.
  task automatic handshake(input logic [7:0] expWord);
    bus.i_rnd_ready = 1'b1;
    tick();
    bus.i_rnd_ready = 1'b0;
    checkOutput("hsValidLow", bus.o_rnd_valid, 0);
    checkOutput("hsWordKept", bus.o_rnd_word, expWord);
    checkOutput("gapBusy1", bus.o_busy, 1);
    tick();
    checkOutput("gapBusy2", bus.o_busy, 1);
    tick();
    checkOutput("gapIdle", bus.o_busy, 0);
  endtask

  task automatic runVector(input vec_t v);
    logic [7:0] expWord;
    expWord = REJ_EN ? v.expEn : v.expDis;
    startPulse();
    applyStimulus(v.first);
    if (REJ_EN && v.rejEn) begin
      checkOutput("rejValid", bus.o_rnd_valid, 0);
      checkOutput("rejBusy", bus.o_busy, 1);
      applyStimulus(v.second);
      if (expRej < 255) expRej++;
    end
    checkOutput("vecValid", bus.o_rnd_valid, 1);
    checkOutput("vecWord", bus.o_rnd_word, expWord);
    checkOutput("vecBusy", bus.o_busy, 1);
    checkOutput("vecRejCnt", bus.o_reject_cnt, expRej);
    handshake(expWord);
  endtask

  initial begin
    assertCount     = 0;
    failCount       = 0;
    expRej          = 0;
    rst_n           = 1'b0;
    bus.i_start     = 1'b0;
    bus.i_rnd_bit   = 1'b0;
    bus.i_rnd_ready = 1'b0;

    //               first   second  expEn   expDis  rejEn
    vecs[0] = '{8'hB2, 8'h00, 8'hB2, 8'hB2, 1'b0};
    vecs[1] = '{8'hF0, 8'h64, 8'h64, 8'hF0, 1'b1};
    vecs[2] = '{8'hC7, 8'h00, 8'hC7, 8'hC7, 1'b0};
    vecs[3] = '{8'hC8, 8'h3C, 8'h3C, 8'hC8, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 8'hC7, 8'hC7, 8'hFF, 1'b1};

    // Reset state.
    #12;
    checkOutput("rstValid", bus.o_rnd_valid, 0);
    checkOutput("rstWord", bus.o_rnd_word, 0);
    checkOutput("rstBusy", bus.o_busy, 0);
    checkOutput("rstRejCnt", bus.o_reject_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Table of words.
    for (int n = 0; n < 6; n++) runVector(vecs[n]);

    // Long hold: the word must stay stable without rnd_ready.
    startPulse();
    applyStimulus(8'hB2);
    checkOutput("holdValid", bus.o_rnd_valid, 1);
    checkOutput("holdWord", bus.o_rnd_word, 8'hB2);
    for (int c = 0; c < 20; c++) begin
      bus.i_rnd_bit = c[0];
      tick();
      checkOutput("holdStable", {bus.o_rnd_valid, bus.o_rnd_word}, {1'b1, 8'hB2});
    end

    // Asynchronous reset while HOLD is waiting, checked before any edge.
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arstValid", bus.o_rnd_valid, 0);
    checkOutput("arstWord", bus.o_rnd_word, 0);
    checkOutput("arstBusy", bus.o_busy, 0);
    checkOutput("arstRejCnt", bus.o_reject_cnt, 0);
    expRej = 0;
    #2 rst_n = 1'b1;
    tick();

    // Partial word cut off by reset: no stale bits may appear.
    startPulse();
    bus.i_rnd_bit = 1'b1;
    repeat (4) tick();
    #3 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    startPulse();
    applyStimulus(8'h3C);
    checkOutput("partValid", bus.o_rnd_valid, 1);
    checkOutput("partWord", bus.o_rnd_word, 8'h3C);
    handshake(8'h3C);

    // start held high with rnd_ready=1: one valid cycle every 12 edges.
    // Each period is 8 collect edges, then the handshake, then 2 gap edges,
    // then the start edge.
    bus.i_rnd_bit   = 1'b0;
    bus.i_rnd_ready = 1'b1;
    bus.i_start     = 1'b1;
    for (int n = 0; n < 36; n++) begin
      tick();
      checkOutput("periodValid", bus.o_rnd_valid, (n % 12 == 8) ? 1 : 0);
      if (n % 12 == 8) checkOutput("periodWord", bus.o_rnd_word, 0);
    end
    bus.i_start     = 1'b0;
    bus.i_rnd_ready = 1'b0;
    tick();
    checkOutput("periodIdle", bus.o_busy, 0);

    // An all-ones stream: each word is rejected when the reject feature is
    // enabled, otherwise 8'hFF is accepted.
    bus.i_rnd_bit = 1'b1;
    startPulse();
`ifdef RAND_REJECT_EN
    repeat (260 * 8) tick();
    checkOutput("satRejCnt", bus.o_reject_cnt, 255);
    checkOutput("satValid", bus.o_rnd_valid, 0);
    checkOutput("satBusy", bus.o_busy, 1);
`else
    repeat (8) tick();
    checkOutput("onesValid", bus.o_rnd_valid, 1);
    checkOutput("onesWord", bus.o_rnd_word, 8'hFF);
    checkOutput("onesRejCnt", bus.o_reject_cnt, 0);
`endif
    #3 rst_n = 1'b0;
    #1;
    checkOutput("endRstBusy", bus.o_busy, 0);
    checkOutput("endRstRejCnt", bus.o_reject_cnt, 0);
    #2 rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
